// File: rtl/clk_div_bank.sv
// Bank of independent 50%-duty clock dividers with a tick on each rising edge.
// Terminal counts reload only at half-period boundaries, so no runt pulses.
module clk_div_bank #(
    parameter int              NUM_CH   = 2,
    parameter int              CNT_W    = 27,
    parameter int              CH_W     = 1,
    parameter logic [CNT_W-1:0] RESET_TC = CNT_W'(999999)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_tc,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_d     [NUM_CH];
    logic [CNT_W-1:0]  tc_q      [NUM_CH];
    logic [CNT_W-1:0]  tc_d      [NUM_CH];
    logic [CNT_W-1:0]  tc_pend_q [NUM_CH];
    logic [CNT_W-1:0]  tc_pend_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    logic cfg_valid;
    assign cfg_valid = cfg_we && (int'(cfg_ch) < NUM_CH);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            logic wr;
            logic bnd;
            wr  = cfg_valid && (int'(cfg_ch) == i);
            bnd = (cnt_q[i] == tc_q[i]);

            cnt_d[i]     = cnt_q[i];
            tc_d[i]      = tc_q[i];
            tc_pend_d[i] = tc_pend_q[i];
            pend_d[i]    = pend_q[i];
            clk_out_d[i] = clk_out_q[i];
            tick_d[i]    = 1'b0;

            if (sync || !en[i] || bnd) begin
                // Every path through here is a reload point: a same-cycle
                // write beats an older pending value.
                if (wr) begin
                    tc_d[i]   = cfg_tc;
                    pend_d[i] = 1'b0;
                end else if (pend_q[i]) begin
                    tc_d[i]   = tc_pend_q[i];
                    pend_d[i] = 1'b0;
                end
                cnt_d[i] = '0;
                if (sync || !en[i]) begin
                    clk_out_d[i] = 1'b0;
                end else begin
                    clk_out_d[i] = ~clk_out_q[i];
                    tick_d[i]    = ~clk_out_q[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                if (wr) begin
                    tc_pend_d[i] = cfg_tc;
                    pend_d[i]    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                tc_q[i]      <= RESET_TC;
                tc_pend_q[i] <= '0;
            end
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= cnt_d[i];
                tc_q[i]      <= tc_d[i];
                tc_pend_q[i] <= tc_pend_d[i];
            end
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: two channels, 8-bit counters, reset tc of 3.
// Inputs change and outputs are sampled on the falling edge.
module tb_clk_div_bank;

    logic       clk;
    logic       rst_n;
    logic [1:0] en;
    logic       sync;
    logic       cfg_we;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_tc;
    logic [1:0] clk_out;
    logic [1:0] tick;
    logic [1:0] pend;

    int n_cmp = 0;
    int n_err = 0;

    clk_div_bank #(
        .NUM_CH  (2),
        .CNT_W   (8),
        .CH_W    (1),
        .RESET_TC(8'd3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .sync   (sync),
        .cfg_we (cfg_we),
        .cfg_ch (cfg_ch),
        .cfg_tc (cfg_tc),
        .clk_out(clk_out),
        .tick   (tick),
        .pend   (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic ch, input logic [7:0] tc);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_tc = tc;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 2'b00;
        sync   = 1'b0;
        cfg_we = 1'b0;
        cfg_ch = 1'b0;
        cfg_tc = 8'd0;
        @(negedge clk);
        step();
        step();
        chk("rst_clk", clk_out, 2'b00);
        chk("rst_tick", tick, 2'b00);
        chk("rst_pend", pend, 2'b00);

        // Both channels at tc=3: rise 4 cycles after enable, period 8.
        rst_n = 1'b1;
        en    = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("run_clk_%0d", k), clk_out, ((k / 4) % 2 == 1) ? 2'b11 : 2'b00);
            chk($sformatf("run_tick_%0d", k), tick, (k % 8 == 4) ? 2'b11 : 2'b00);
        end

        // ch0 -> tc=1 written mid half-period.
        step();                                   // 17
        wr(1'b0, 8'd1);
        step();                                   // 18
        chk("wr0_pend_a", pend, 2'b01);
        cfg_we = 1'b0;
        step();                                   // 19
        chk("wr0_pend_b", pend, 2'b01);
        chk("wr0_clk_hold", clk_out, 2'b00);
        step();                                   // 20
        chk("wr0_bnd_clk", clk_out, 2'b11);
        chk("wr0_bnd_tick", tick, 2'b11);
        chk("wr0_bnd_pend", pend, 2'b00);
        step();                                   // 21
        chk("wr0_clk_21", clk_out, 2'b11);
        chk("wr0_tick_21", tick, 2'b00);
        step();                                   // 22
        chk("wr0_clk_22", clk_out, 2'b10);
        step();                                   // 23
        chk("wr0_clk_23", clk_out, 2'b10);
        step();                                   // 24
        chk("wr0_clk_24", clk_out, 2'b01);
        chk("wr0_tick_24", tick, 2'b01);

        // ch1: tc=5 then tc=2 before the boundary; only tc=2 is used.
        wr(1'b1, 8'd5);
        step();                                   // 25
        chk("wr1_pend_a", pend, 2'b10);
        wr(1'b1, 8'd2);
        step();                                   // 26
        chk("wr1_pend_b", pend, 2'b10);
        cfg_we = 1'b0;
        step();                                   // 27
        chk("wr1_pend_c", pend, 2'b10);
        chk("wr1_clk_27", {1'b0, clk_out[1]}, 2'b00);
        step();                                   // 28
        chk("wr1_clk_28", {1'b0, clk_out[1]}, 2'b01);
        chk("wr1_tick_28", {1'b0, tick[1]}, 2'b01);
        chk("wr1_pend_28", pend, 2'b00);
        step();                                   // 29
        step();                                   // 30
        chk("wr1_clk_30", {1'b0, clk_out[1]}, 2'b01);
        step();                                   // 31
        chk("wr1_clk_31", {1'b0, clk_out[1]}, 2'b00);
        step();                                   // 32
        step();                                   // 33
        step();                                   // 34
        chk("wr1_clk_34", {1'b0, clk_out[1]}, 2'b01);
        chk("wr1_tick_34", {1'b0, tick[1]}, 2'b01);

        // ch0 write landing exactly on its boundary edge.
        step();                                   // 35
        wr(1'b0, 8'd3);
        step();                                   // 36
        chk("bnd_clk_36", {1'b0, clk_out[0]}, 2'b01);
        chk("bnd_tick_36", {1'b0, tick[0]}, 2'b01);
        chk("bnd_pend_36", {1'b0, pend[0]}, 2'b00);
        cfg_we = 1'b0;
        step();                                   // 37
        chk("bnd_pend_37", {1'b0, pend[0]}, 2'b00);
        chk("bnd_clk_37", {1'b0, clk_out[0]}, 2'b01);
        step();                                   // 38
        step();                                   // 39
        chk("bnd_clk_39", {1'b0, clk_out[0]}, 2'b01);
        step();                                   // 40
        chk("bnd_clk_40", {1'b0, clk_out[0]}, 2'b00);

        // Disabled writes load directly; staggered start, then sync realigns.
        en = 2'b00;
        step();                                   // 41
        chk("dis_clk", clk_out, 2'b00);
        wr(1'b0, 8'd2);
        step();                                   // 42
        chk("dis_pend_a", pend, 2'b00);
        en = 2'b01;
        wr(1'b1, 8'd2);
        step();                                   // 43
        chk("dis_pend_b", pend, 2'b00);
        chk("dis_clk_43", clk_out, 2'b00);
        cfg_we = 1'b0;
        step();                                   // 44
        step();                                   // 45
        chk("stag_clk_45", clk_out, 2'b01);
        en = 2'b11;
        step();                                   // 46
        chk("stag_clk_46", clk_out, 2'b01);
        step();                                   // 47
        step();                                   // 48
        chk("stag_clk_48", clk_out, 2'b10);
        sync = 1'b1;
        step();                                   // 49
        chk("sync_clk", clk_out, 2'b00);
        chk("sync_tick", tick, 2'b00);
        sync = 1'b0;
        step();                                   // 50
        step();                                   // 51
        chk("sync_clk_51", clk_out, 2'b00);
        step();                                   // 52
        chk("sync_clk_52", clk_out, 2'b11);
        chk("sync_tick_52", tick, 2'b11);

        // Reset while a write is pending discards it and restores tc=3.
        wr(1'b0, 8'd7);
        step();                                   // 53
        chk("prst_pend", pend, 2'b01);
        chk("prst_clk", clk_out, 2'b11);
        cfg_we = 1'b0;
        rst_n  = 1'b0;
        step();                                   // 54
        chk("mrst_clk", clk_out, 2'b00);
        chk("mrst_tick", tick, 2'b00);
        chk("mrst_pend", pend, 2'b00);
        rst_n = 1'b1;
        step();                                   // 55
        step();                                   // 56
        step();                                   // 57
        chk("mrst_clk_57", clk_out, 2'b00);
        step();                                   // 58
        chk("mrst_clk_58", clk_out, 2'b11);
        chk("mrst_tick_58", tick, 2'b11);
        step();                                   // 59
        step();                                   // 60
        step();                                   // 61
        chk("mrst_clk_61", clk_out, 2'b11);
        step();                                   // 62
        chk("mrst_clk_62", clk_out, 2'b00);
        chk("mrst_pend_62", pend, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of independent clock dividers. All channels run from the single system clock and each one produces a 50 %-duty divided square wave plus a one-cycle rising-edge tick. Each channel has a run-time programmable terminal count with glitch-free reload at half-period boundaries, a per-channel enable, and a global phase-align restart. It replaces fixed-rate divider instances, such as the 50 Hz and 700 Hz refresh/scan clocks, with one configurable block.

## Interface
- NUM_CH, 2: number of divider channels (1..16).
- CNT_W, 27: counter and terminal-count width in bits.
- CH_W, 1: width of cfg_ch; must satisfy 2^CH_W >= NUM_CH.
- RESET_TC, 999999: terminal count loaded into every channel at reset.

- clk  in  1: system clock; all logic on the rising edge.
- rst_n  in  1: synchronous, active-low reset.
- en  in  NUM_CH: per-channel run enable.
- sync  in  1: global restart pulse; phase-aligns all channels.
- cfg_we  in  1: terminal-count write strobe.
- cfg_ch  in  CH_W: target channel for the write.
- cfg_tc  in  CNT_W: new terminal count.
- clk_out  out  NUM_CH: divided square waves, registered.
- tick  out  NUM_CH: one-cycle pulse in the cycle clk_out[i] rises, registered.
- pend  out  NUM_CH: a written terminal count is waiting for its channel's boundary.

## Operation
- Per-channel state: cnt[CNT_W], tc[CNT_W], tc_pend[CNT_W], pend, clk_out, tick.
- Half-period is tc+1 cycles and the full period is 2*(tc+1) cycles. tc=0 gives clk/2. No tc value is illegal.
- Reset, when rst_n=0 at a clock edge:
  - cnt=0, tc=RESET_TC, pend=0, clk_out=0, tick=0 for every channel.
  - Overrides every other input.
- Running channel (en[i]=1, sync=0):
  - If cnt==tc: cnt<=0, clk_out<=~clk_out, tick<=~clk_out (1 only on a rising toggle).
  - Also at that boundary: if pend, tc<=tc_pend and pend<=0.
  - Otherwise cnt<=cnt+1 and tick<=0.
- Disabled channel (en[i]=0):
  - cnt<=0, clk_out<=0, tick<=0.
  - A pending value is applied immediately: tc<=tc_pend, pend<=0.
- Write, when cfg_we=1 and cfg_ch<NUM_CH:
  - Running channel, not at its boundary: tc_pend<=cfg_tc and pend<=1. A later write before the boundary overwrites tc_pend.
  - Running channel, at its boundary that same cycle: tc<=cfg_tc directly and pend<=0. The new write wins over any older pending value.
  - Channel disabled, or sync=1: tc<=cfg_tc directly and pend<=0.
- If cfg_ch>=NUM_CH the write is ignored and no state changes.
- sync=1 (rst_n=1), all channels regardless of en:
  - cnt<=0, clk_out<=0, tick<=0.
  - Pending values are applied (tc<=tc_pend, pend<=0), unless a same-cycle write targets that channel, in which case the written value is loaded.
- tc reloads only at a boundary, so there are no runt pulses. Each half-period uses exactly one tc value.
- Counter never exceeds tc. If a reload shrinks tc, the new value takes effect only after cnt restarts at 0.

## Timing
- All outputs are registered. Reset values: clk_out=0, tick=0, pend=0.
- Enable start: en[i] sampled high at edge E0 (cnt=0). clk_out[i] and tick[i] first go high after edge E0+tc, visible tc+1 cycles after en is sampled.
- tick[i] is high for exactly one cycle, coincident with the cycle clk_out[i] is first high. It repeats every 2*(tc+1) cycles.
- Write latency: pend[i] rises the cycle after cfg_we. The new tc governs the half-period that starts after the next boundary.
- Deassert en: clk_out drops to 0 the cycle after en is sampled low, which may truncate a high phase. This is intended.
- sync: every channel with en=1 restarts in lockstep. Channels with equal tc produce identical clk_out waveforms from then on.
- Mid-operation reset: all channels return to the reset state in one cycle. Pending writes are discarded.

## Test plan
Bench configuration for all scenarios: NUM_CH=2, CNT_W=8, CH_W=1, RESET_TC=3.
- Reset, then en=2'b11 held: clk_out toggles every 4 cycles on both channels (period 8). tick is high 1 cycle in 8. First rise is 4 cycles after en.
- Write ch0 tc=1 mid-half-period: pend[0]=1 until the next boundary. The current half-period stays 4 cycles, then half-periods are 2 cycles and pend[0]=0. ch1 is unchanged.
- Write ch1 with tc=5, then tc=2, before the boundary: ch1 adopts tc=2 at the boundary. tc=5 is never used.
- Write that lands on ch0's boundary cycle: the new tc applies to the immediately following half-period, and pend[0] never asserts.
- ch0 tc=2, ch1 tc=2 started 3 cycles apart, then pulse sync: after sync both clk_out are identical, and both rise 3 cycles after sync. Writes with cfg_ch=1 while en[1]=0 update ch1's tc directly, so pend[1] stays 0.
- rst_n=0 for one cycle while running with pend=1: the next cycle shows clk_out=0, tick=0, pend=0 and tc=3 on both channels. The pending value is lost.
